// File: rtl/conv_encoder_framer.sv
// Rate-1/2 K=3 convolutional encoder with frame tail insertion.
// One registered 2-bit symbol per bit, valid/ready on both sides.
module conv_encoder_framer #(
  parameter int         FRAME_LEN = 8,
  parameter logic [2:0] G0        = 3'b111,
  parameter logic [2:0] G1        = 3'b101
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       refresh,
  input  logic       valid_in,
  input  logic       data_in,
  output logic       ready_out,
  input  logic       ready_in,
  output logic       valid_out,
  output logic [1:0] symbol_out,
  output logic [2:0] write_pointer_out,
  output logic       frame_start,
  output logic       frame_end
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TAIL = 2'd2
  } state_e;

  localparam logic [7:0] LAST = 8'(FRAME_LEN);

  state_e     state_q;
  logic [1:0] s_q;
  logic [7:0] bit_cnt_q;
  logic       tail_cnt_q;
  logic       valid_q;
  logic [1:0] sym_q;
  logic [2:0] wp_q;
  logic       fs_q;
  logic       fe_q;

  logic       slot_free;
  logic       accept;
  logic       d_eff;
  logic [2:0] taps;
  logic [1:0] enc_d;

  assign slot_free = !valid_q || ready_in;
  assign ready_out = slot_free && (state_q != TAIL);
  assign accept    = valid_in && ready_out;

  // Tail symbols flush the trellis with forced zero input
  always_comb begin
    d_eff = data_in;
    if (state_q == TAIL) d_eff = 1'b0;
    taps  = {d_eff, s_q};
    enc_d = {^(G0 & taps), ^(G1 & taps)};
  end

  // Framer FSM, encoder state and registered output slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      s_q        <= 2'b00;
      bit_cnt_q  <= 8'd0;
      tail_cnt_q <= 1'b0;
      valid_q    <= 1'b0;
      sym_q      <= 2'b00;
      wp_q       <= 3'd0;
      fs_q       <= 1'b0;
      fe_q       <= 1'b0;
    end else if (refresh) begin
      state_q    <= IDLE;
      s_q        <= 2'b00;
      bit_cnt_q  <= 8'd0;
      tail_cnt_q <= 1'b0;
      valid_q    <= 1'b0;
      sym_q      <= 2'b00;
      wp_q       <= 3'd0;
      fs_q       <= 1'b0;
      fe_q       <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            sym_q     <= enc_d;
            valid_q   <= 1'b1;
            s_q       <= {data_in, s_q[1]};
            bit_cnt_q <= 8'd1;
            wp_q      <= 3'd0;
            fs_q      <= 1'b1;
            fe_q      <= 1'b0;
            state_q   <= (FRAME_LEN == 1) ? TAIL : DATA;
          end else if (slot_free) begin
            valid_q <= 1'b0;
          end
        end
        DATA: begin
          if (accept) begin
            sym_q     <= enc_d;
            valid_q   <= 1'b1;
            s_q       <= {data_in, s_q[1]};
            bit_cnt_q <= bit_cnt_q + 8'd1;
            wp_q      <= wp_q + 3'd1;
            fs_q      <= 1'b0;
            fe_q      <= 1'b0;
            if (bit_cnt_q + 8'd1 == LAST) state_q <= TAIL;
          end else if (slot_free) begin
            valid_q <= 1'b0;
          end
        end
        TAIL: begin
          if (slot_free) begin
            sym_q      <= enc_d;
            valid_q    <= 1'b1;
            s_q        <= {1'b0, s_q[1]};
            wp_q       <= wp_q + 3'd1;
            fs_q       <= 1'b0;
            tail_cnt_q <= ~tail_cnt_q;
            if (tail_cnt_q) begin
              fe_q    <= 1'b1;
              s_q     <= 2'b00;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign valid_out         = valid_q;
  assign symbol_out        = sym_q;
  assign write_pointer_out = wp_q;
  assign frame_start       = fs_q;
  assign frame_end         = fe_q;

endmodule

// File: tb/tb_conv_encoder_framer.sv
// Directed bench for conv_encoder_framer.
// Hand-computed symbol streams, backpressure, refresh, async reset.
module tb_conv_encoder_framer;

  logic       clk;
  logic       rst;
  logic       refresh;
  logic       valid_in;
  logic       data_in;
  logic       ready_out;
  logic       ready_in;
  logic       valid_out;
  logic [1:0] symbol_out;
  logic [2:0] write_pointer_out;
  logic       frame_start;
  logic       frame_end;

  int vectors;
  int miscompares;

  conv_encoder_framer dut (
    .clk               (clk),
    .rst               (rst),
    .refresh           (refresh),
    .valid_in          (valid_in),
    .data_in           (data_in),
    .ready_out         (ready_out),
    .ready_in          (ready_in),
    .valid_out         (valid_out),
    .symbol_out        (symbol_out),
    .write_pointer_out (write_pointer_out),
    .frame_start       (frame_start),
    .frame_end         (frame_end)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // bits[7] is sent first; symbol i lives at exp[19-2i -: 2]
  localparam logic [7:0]  B1 = 8'b1011_0000;
  localparam logic [19:0] E1 = 20'b11_10_00_01_01_11_00_00_00_00;
  localparam logic [7:0]  B2 = 8'b1111_1111;
  localparam logic [19:0] E2 = 20'b11_01_10_10_10_10_10_10_01_11;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v,
                         input logic [1:0] s, input logic [2:0] wp,
                         input logic fs, input logic fe);
    chk(tag, {valid_out, symbol_out, write_pointer_out,
              frame_start, frame_end},
        {v, s, wp, fs, fe});
  endtask

  task automatic drive(input logic v, input logic d, input logic r);
    valid_in = v;
    data_in  = d;
    ready_in = r;
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic data_phase(input string tag, input logic [7:0] bits,
                            input logic [19:0] exp, input int n,
                            input int stall_at);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, bits[7-i], 1'b1);
      tick;
      chk_out(tag, 1'b1, exp[19-2*i -: 2], 3'(i), (i == 0), 1'b0);
      if (i == stall_at) begin
        drive(1'b1, bits[6-i], 1'b0);
        #1 chk({tag, "_stall_rdy"}, 8'(ready_out), 8'd0);
        repeat (3) begin
          tick;
          chk_out({tag, "_hold"}, 1'b1, exp[19-2*i -: 2], 3'(i),
                  (i == 0), 1'b0);
        end
      end
    end
  endtask

  task automatic tail_phase(input string tag, input logic [19:0] exp,
                            input logic nv, input logic nd);
    drive(nv, nd, 1'b1);
    #1 chk({tag, "_rdy_t0"}, 8'(ready_out), 8'd0);
    tick;
    chk_out({tag, "_tail1"}, 1'b1, exp[3:2], 3'd0, 1'b0, 1'b0);
    chk({tag, "_rdy_t1"}, 8'(ready_out), 8'd0);
    tick;
    chk_out({tag, "_tail2"}, 1'b1, exp[1:0], 3'd1, 1'b0, 1'b1);
    chk({tag, "_rdy_idle"}, 8'(ready_out), 8'd1);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    refresh     = 1'b0;
    drive(1'b0, 1'b0, 1'b1);

    // reset state
    tick;
    chk_out("reset", 1'b0, 2'b00, 3'd0, 1'b0, 1'b0);
    chk("reset_rdy", 8'(ready_out), 8'd1);
    rst = 1'b0;
    tick;
    chk_out("idle", 1'b0, 2'b00, 3'd0, 1'b0, 1'b0);

    // case 1: basic frame
    data_phase("c1", B1, E1, 8, 99);
    tail_phase("c1", E1, 1'b0, 1'b0);
    tick;
    chk_out("c1_drain", 1'b0, 2'b00, 3'd1, 1'b0, 1'b1);

    // case 2: all ones
    data_phase("c2", B2, E2, 8, 99);
    tail_phase("c2", E2, 1'b0, 1'b0);
    tick;

    // case 3: backpressure after third symbol
    data_phase("c3", B1, E1, 8, 2);
    tail_phase("c3", E1, 1'b0, 1'b0);
    tick;

    // case 4: refresh after fifth bit, with a bit offered
    data_phase("c4", B2, E2, 5, 99);
    drive(1'b1, 1'b1, 1'b1);
    refresh = 1'b1;
    tick;
    refresh = 1'b0;
    drive(1'b0, 1'b0, 1'b1);
    chk_out("c4_refresh", 1'b0, 2'b00, 3'd0, 1'b0, 1'b0);
    #1 chk("c4_rdy", 8'(ready_out), 8'd1);
    tick;
    data_phase("c4b", B1, E1, 8, 99);
    tail_phase("c4b", E1, 1'b0, 1'b0);
    tick;

    // case 5: async reset during tail
    data_phase("c5", B1, E1, 8, 99);
    drive(1'b0, 1'b0, 1'b1);
    tick;
    chk_out("c5_tail1", 1'b1, 2'b00, 3'd0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1 chk_out("c5_async", 1'b0, 2'b00, 3'd0, 1'b0, 1'b0);
    chk("c5_rdy", 8'(ready_out), 8'd1);
    tick;
    rst = 1'b0;
    chk_out("c5_noend", 1'b0, 2'b00, 3'd0, 1'b0, 1'b0);
    tick;
    chk_out("c5_still", 1'b0, 2'b00, 3'd0, 1'b0, 1'b0);

    // case 6: back-to-back frames, valid_in held high
    data_phase("c6a", B2, E2, 8, 99);
    tail_phase("c6a", E2, 1'b1, B1[7]);
    data_phase("c6b", B1, E1, 8, 99);
    tail_phase("c6b", E1, 1'b0, 1'b0);
    tick;
    chk_out("c6_drain", 1'b0, 2'b00, 3'd1, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
